// File: rtl/keypad_matrix_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_scanner_pkg
// Purpose  : Shared key codes and matrix position-to-code map for 4x3 keypads
// Revision : 1.0 - initial release
// ============================================================================
package keypad_matrix_scanner_pkg;

    localparam logic [3:0] KC_0    = 4'd0;
    localparam logic [3:0] KC_1    = 4'd1;
    localparam logic [3:0] KC_2    = 4'd2;
    localparam logic [3:0] KC_3    = 4'd3;
    localparam logic [3:0] KC_4    = 4'd4;
    localparam logic [3:0] KC_5    = 4'd5;
    localparam logic [3:0] KC_6    = 4'd6;
    localparam logic [3:0] KC_7    = 4'd7;
    localparam logic [3:0] KC_8    = 4'd8;
    localparam logic [3:0] KC_9    = 4'd9;
    localparam logic [3:0] KC_STAR = 4'd10;
    localparam logic [3:0] KC_HASH = 4'd11;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = 12;

    // Entry (row*3 + col) holds the code of the key at that matrix position.
    localparam logic [11:0][3:0] KEY_MAP = {
        KC_HASH, KC_0, KC_STAR,
        KC_9,    KC_8, KC_7,
        KC_6,    KC_5, KC_4,
        KC_3,    KC_2, KC_1
    };

    function automatic logic [3:0] rc_to_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{2'b00, row} * 4'd3 + {2'b00, col}];
    endfunction

    function automatic logic [2:0] col_drive_n(input logic [1:0] col);
        return ~(3'b001 << col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_scanner_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for asynchronous level inputs
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_scanner
// Purpose  : 4x3 keypad column scanner with snapshot debounce, level outputs
//            and a single-cycle new-key event
// Revision : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int SETTLE_CYC     = 1000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW_N,
    output logic [2:0] COL_N,
    output logic [9:0] KEY,
    output logic       KEY_STAR,
    output logic       KEY_HASH,
    output logic       KEY_VALID,
    output logic [3:0] KEY_CODE
);

    localparam int c_dwell_w = $clog2(SETTLE_CYC);
    localparam int c_cnt_w   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SETTLE_CYC - 2);
    localparam logic [c_cnt_w-1:0]   c_deb        = c_cnt_w'(DEBOUNCE_SCANS);
    localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_drive  = 2'd1;
    localparam logic [1:0] c_st_sample = 2'd2;
    localparam logic [1:0] c_st_eval   = 2'd3;

    logic [3:0]           w_rows_n;
    logic [1:0]           r_state;
    logic [c_dwell_w-1:0] r_dwell;
    logic [1:0]           r_col;
    logic [2:0]           r_col_n;
    logic [11:0]          r_snap;
    logic [11:0]          r_prev;
    logic [11:0]          r_stable;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_valid;
    logic [3:0]           r_code;

    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 w_commit;
    logic [11:0]          w_new;
    logic [3:0]           w_new_code;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk (CLK),
        .rst (RST),
        .i_d (ROW_N),
        .o_q (w_rows_n)
    );

    always_comb begin
        w_cnt_next = c_cnt_one;
        if (r_snap == r_prev) begin
            w_cnt_next = (r_cnt == c_deb) ? c_deb : r_cnt + 1'b1;
        end
        w_commit = (w_cnt_next == c_deb) && (r_snap != r_stable);
        w_new    = r_snap & ~r_stable;
        // Lowest newly pressed code wins when several arrive together.
        w_new_code = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_new[i]) begin
                w_new_code = 4'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_st_idle;
            r_dwell  <= '0;
            r_col    <= 2'd0;
            r_col_n  <= 3'b111;
            r_snap   <= '0;
            r_prev   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_code   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_state <= c_st_drive;
                    r_dwell <= '0;
                    r_col   <= 2'd0;
                    r_col_n <= col_drive_n(2'd0);
                end
                c_st_drive: begin
                    if (r_dwell == c_dwell_last) begin
                        r_state <= c_st_sample;
                        r_dwell <= '0;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                c_st_sample: begin
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        r_snap[rc_to_code(2'(r), r_col)] <= ~w_rows_n[r];
                    end
                    if (r_col == 2'd2) begin
                        r_state <= c_st_eval;
                        r_col_n <= 3'b111;
                    end else begin
                        r_state <= c_st_drive;
                        r_col   <= r_col + 1'b1;
                        r_col_n <= col_drive_n(r_col + 1'b1);
                    end
                end
                c_st_eval: begin
                    r_cnt  <= w_cnt_next;
                    r_prev <= r_snap;
                    if (w_commit) begin
                        r_stable <= r_snap;
                        if (|w_new) begin
                            r_valid <= 1'b1;
                            r_code  <= w_new_code;
                        end
                    end
                    r_state <= c_st_drive;
                    r_col   <= 2'd0;
                    r_col_n <= col_drive_n(2'd0);
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign COL_N     = r_col_n;
    assign KEY       = r_stable[9:0];
    assign KEY_STAR  = r_stable[KC_STAR];
    assign KEY_HASH  = r_stable[KC_HASH];
    assign KEY_VALID = r_valid;
    assign KEY_CODE  = r_code;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_matrix_scanner
// Purpose  : Scan-level keypad model driving the scanner, with an event
//            scoreboard and per-scan level checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

    localparam int S   = 16;
    localparam int DEB = 5;
    localparam int P   = 3 * S + 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] ROW_N;
    logic [2:0] COL_N;
    logic [9:0] KEY;
    logic       KEY_STAR;
    logic       KEY_HASH;
    logic       KEY_VALID;
    logic [3:0] KEY_CODE;

    always #5 CLK = ~CLK;

    keypad_matrix_scanner #(
        .SETTLE_CYC     (S),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ROW_N     (ROW_N),
        .COL_N     (COL_N),
        .KEY       (KEY),
        .KEY_STAR  (KEY_STAR),
        .KEY_HASH  (KEY_HASH),
        .KEY_VALID (KEY_VALID),
        .KEY_CODE  (KEY_CODE)
    );

    typedef struct {
        int          code;
        logic [11:0] levels;
        longint      when;
    } ev_t;

    ev_t         exp_q[$];
    logic [11:0] hist[$];
    logic [11:0] held = '0;
    logic [11:0] m_stable = '0;
    int          m_code = 0;
    int          scan_idx = 0;
    int          vectors = 0;
    int          miscompares = 0;
    longint      cyc = 0;
    longint      base = 0;
    bit          running = 1'b0;
    bit          resetting = 1'b0;

    function automatic int code_at(int r, int c);
        if (r == 3) return (c == 0) ? 10 : ((c == 1) ? 0 : 11);
        return r * 3 + c + 1;
    endfunction

    function automatic logic [11:0] kb(int k);
        logic [11:0] one = 12'd1;
        return one << k;
    endfunction

    // Physical keypad: a row reads low when a held key joins it to a low column.
    always_comb begin
        ROW_N = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (COL_N[c] == 1'b0 && held[code_at(r, c)]) ROW_N[r] = 1'b0;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: the stable set follows a snapshot once the last DEB scans agree.
    task automatic model_scan(input logic [11:0] s);
        logic [11:0] fresh;
        bit settled;
        int lo;
        hist.push_back(s);
        if (hist.size() > DEB) void'(hist.pop_front());
        settled = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != s) settled = 1'b0;
        if (settled && s != m_stable) begin
            fresh = s & ~m_stable;
            m_stable = s;
            if (fresh != 0) begin
                lo = 0;
                while (!fresh[lo]) lo++;
                m_code = lo;
                exp_q.push_back('{lo, s, base + longint'(scan_idx + 1) * P});
            end
        end
        scan_idx++;
    endtask

    task automatic check_levels();
        vectors++;
        if ({KEY_HASH, KEY_STAR, KEY} !== m_stable || KEY_CODE !== 4'(m_code)) begin
            miscompares++;
            $display("FAIL levels scan %0d: got hash=%b star=%b key=%b code=%0d, want levels=%b code=%0d",
                     scan_idx, KEY_HASH, KEY_STAR, KEY, KEY_CODE, m_stable, m_code);
        end
    endtask

    task automatic run_scans(input logic [11:0] s, input int n);
        repeat (n) begin
            held = s;
            model_scan(s);
            repeat (P) @(posedge CLK);
            #1;
            check_levels();
        end
    endtask

    task automatic check_drained(input string tag);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected pulses not seen, want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input int n);
        check_drained("pending_before_reset");
        @(negedge CLK);
        RST = 1'b1;
        running = 1'b0;
        @(posedge CLK);
        #1 resetting = 1'b1;
        repeat (n - 1) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        resetting = 1'b0;
        running = 1'b1;
        base = cyc;
        hist.delete();
        m_stable = '0;
        m_code = 0;
        scan_idx = 0;
    endtask

    // Monitor: reset values, column pattern and pulse scoreboard.
    always @(negedge CLK) begin
        int m;
        logic [2:0] expc;
        ev_t e;
        if (resetting) begin
            vectors++;
            if (COL_N !== 3'b111 || KEY !== 10'd0 || KEY_STAR !== 1'b0 || KEY_HASH !== 1'b0 ||
                KEY_VALID !== 1'b0 || KEY_CODE !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_values: got col_n=%b key=%b star=%b hash=%b valid=%b code=%0d, want 111/0",
                         COL_N, KEY, KEY_STAR, KEY_HASH, KEY_VALID, KEY_CODE);
            end
        end else if (running) begin
            m = int'((cyc - base) % P);
            expc = (m == 3 * S) ? 3'b111 : ~(3'b001 << (m / S));
            vectors++;
            if (COL_N !== expc) begin
                miscompares++;
                $display("FAIL col_n at scan cycle %0d: got %b, want %b", m, COL_N, expc);
            end
            if (KEY_VALID !== 1'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse at cycle %0d: got code=%0d, want no pulse",
                             cyc - base, KEY_CODE);
                end else begin
                    e = exp_q.pop_front();
                    if (KEY_CODE !== 4'(e.code) || {KEY_HASH, KEY_STAR, KEY} !== e.levels || cyc != e.when) begin
                        miscompares++;
                        $display("FAIL pulse: got code=%0d levels=%b cycle=%0d, want code=%0d levels=%b cycle=%0d",
                                 KEY_CODE, {KEY_HASH, KEY_STAR, KEY}, cyc - base,
                                 e.code, e.levels, e.when - base);
                    end
                end
            end
        end
    end

    initial begin
        logic [11:0] s;
        do_reset(5);
        run_scans('0, 2);
        run_scans(kb(5), 10);
        run_scans('0, 7);
        for (int i = 0; i < 8; i++) run_scans((i % 2 == 0) ? kb(8) : 12'd0, $urandom_range(1, 2));
        run_scans(kb(8), 7);
        run_scans('0, 6);
        run_scans(kb(11), 6);
        run_scans('0, 6);
        run_scans(kb(10), 6);
        run_scans('0, 6);
        run_scans(kb(3), 8);
        run_scans(kb(3) | kb(7), 7);
        run_scans('0, 6);
        run_scans(kb(2) | kb(9), 6);
        run_scans('0, 6);
        for (int i = 0; i < 24; i++) begin
            s = '0;
            if ($urandom_range(0, 2) >= 1) s = s | kb($urandom_range(0, 11));
            if ($urandom_range(0, 1) == 1) s = s | kb($urandom_range(0, 11));
            run_scans(s, $urandom_range(1, 7));
        end
        run_scans('0, 6);
        run_scans(kb(1), 7);
        repeat ($urandom_range(1, 3 * S - 1)) @(posedge CLK);
        do_reset(1);
        run_scans(kb(1), 7);
        run_scans('0, 6);
        @(negedge CLK);
        #1;
        check_drained("pending_at_end");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
